// File: rtl/ee2026_pkg.sv
// Shared encodings for the EE2026 LED/7-segment blocks: FSM states,
// LED regions, direction values and the system tick rate.
package ee2026_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [1:0] REG_MID   = 2'b00;
    localparam logic [1:0] REG_LEFT  = 2'b01;
    localparam logic [1:0] REG_RIGHT = 2'b10;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam int TICK_HZ = 100;

endpackage

// File: rtl/blink_gen.sv
// Tick-qualified square wave: phase toggles every HALF ticks, free-running from reset.
module blink_gen #(
    parameter int HALF = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic phase
);

    localparam int W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [W-1:0] cnt_reg;
    logic         phase_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (tick) begin
            if (cnt_reg == W'(HALF - 1)) begin
                cnt_reg   <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                cnt_reg <= cnt_reg + W'(1);
            end
        end
    end

    assign phase = phase_reg;

endmodule

// File: rtl/bounce_led_engine.sv
// Single dot bouncing across an N_LED bar with separate up/down step periods,
// run/pause/restart/reverse control and blinking edge regions.
module bounce_led_engine
    import ee2026_pkg::*;
#(
    parameter int N_LED     = 16,
    parameter int POS_W     = $clog2(N_LED),
    parameter int LB        = 10,
    parameter int RB        = 2,
    parameter int START_POS = 7,
    parameter int START_DIR = 0,
    parameter int T_UP      = 160,
    parameter int T_DOWN    = 50,
    parameter int CNT_W     = 8,
    parameter int BL_HALF   = 10,
    parameter int BR_HALF   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             pause_tgl,
    input  logic             reverse,
    output logic [N_LED-1:0] led,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic [1:0]       region,
    output logic             running
);

    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(N_LED - 1);
    localparam logic [POS_W-1:0] POS_START = POS_W'(START_POS);
    localparam logic             DIR_START = (START_DIR != 0);

    state_t             state_reg;
    logic [POS_W-1:0]   pos_reg;
    logic               dir_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               running_reg;
    logic [N_LED-1:0]   led_reg;
    logic [N_LED-1:0]   led_next;
    logic [CNT_W-1:0]   period_m1;
    logic [POS_W-1:0]   step_pos;
    logic               step_dir;
    logic               left_phase;
    logic               right_phase;
    logic               lit_bit;

    blink_gen #(.HALF(BL_HALF)) u_blink_left (
        .clk(clk), .rst(rst), .tick(tick), .phase(left_phase)
    );

    blink_gen #(.HALF(BR_HALF)) u_blink_right (
        .clk(clk), .rst(rst), .tick(tick), .phase(right_phase)
    );

    assign period_m1 = (dir_reg == DIR_UP) ? CNT_W'(T_UP - 1) : CNT_W'(T_DOWN - 1);

    // Bounce turns around on the step off an end, so no end position dwells twice.
    always_comb begin
        step_pos = pos_reg;
        step_dir = dir_reg;
        if (dir_reg == DIR_UP && pos_reg == POS_LAST) begin
            step_pos = POS_LAST - POS_W'(1);
            step_dir = DIR_DOWN;
        end else if (dir_reg == DIR_DOWN && pos_reg == '0) begin
            step_pos = POS_W'(1);
            step_dir = DIR_UP;
        end else if (dir_reg == DIR_UP) begin
            step_pos = pos_reg + POS_W'(1);
        end else begin
            step_pos = pos_reg - POS_W'(1);
        end
    end

    always_comb begin
        region = REG_MID;
        if (pos_reg > POS_W'(LB)) begin
            region = REG_LEFT;
        end else if (pos_reg < POS_W'(RB)) begin
            region = REG_RIGHT;
        end
    end

    always_comb begin
        lit_bit = 1'b1;
        case (region)
            REG_LEFT:  lit_bit = left_phase;
            REG_RIGHT: lit_bit = right_phase;
            default:   lit_bit = 1'b1;
        endcase
    end

    for (genvar gi = 0; gi < N_LED; gi++) begin : g_led
        assign led_next[gi] = (pos_reg == POS_W'(gi)) && lit_bit && (state_reg != ST_IDLE);
    end

    // Input priority within a cycle: start, then pause_tgl, then reverse, then tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pos_reg     <= POS_START;
            dir_reg     <= DIR_START;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
        end else if (start) begin
            state_reg   <= ST_RUN;
            pos_reg     <= POS_START;
            dir_reg     <= DIR_START;
            cnt_reg     <= '0;
            running_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (pause_tgl) begin
                        state_reg   <= ST_PAUSE;
                        running_reg <= 1'b0;
                    end else if (reverse) begin
                        dir_reg <= ~dir_reg;
                        cnt_reg <= '0;
                    end else if (tick) begin
                        if (cnt_reg == period_m1) begin
                            cnt_reg <= '0;
                            pos_reg <= step_pos;
                            dir_reg <= step_dir;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_tgl) begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    running_reg <= 1'b0;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    running_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg <= '0;
        end else begin
            led_reg <= led_next;
        end
    end

    assign led     = led_reg;
    assign pos     = pos_reg;
    assign dir     = dir_reg;
    assign running = running_reg;

endmodule

// File: tb/tb_bounce_led_engine.sv
// Directed bench for bounce_led_engine with a tick-counting reference model
// checked every cycle, plus hand-computed checkpoints.
module tb_bounce_led_engine;

    localparam int N_LED     = 16;
    localparam int POS_W     = 4;
    localparam int LB        = 10;
    localparam int RB        = 2;
    localparam int START_POS = 7;
    localparam int START_DIR = 0;
    localparam int T_UP      = 3;
    localparam int T_DOWN    = 5;
    localparam int CNT_W     = 8;
    localparam int BL_HALF   = 2;
    localparam int BR_HALF   = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             start = 1'b0;
    logic             pause_tgl = 1'b0;
    logic             reverse = 1'b0;
    logic [N_LED-1:0] led;
    logic [POS_W-1:0] pos;
    logic             dir;
    logic [1:0]       region;
    logic             running;

    int n_cmp  = 0;
    int n_fail = 0;

    bounce_led_engine #(
        .N_LED(N_LED), .POS_W(POS_W), .LB(LB), .RB(RB),
        .START_POS(START_POS), .START_DIR(START_DIR),
        .T_UP(T_UP), .T_DOWN(T_DOWN), .CNT_W(CNT_W),
        .BL_HALF(BL_HALF), .BR_HALF(BR_HALF)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .pause_tgl(pause_tgl), .reverse(reverse),
        .led(led), .pos(pos), .dir(dir), .region(region), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 run, 2 pause; a step happens once the
    // number of ticks since the last start/reverse/step reaches the period.
    int          m_mode, m_pos, m_dir, m_since, m_ticks, m_period;
    int          m_region, m_bit;
    logic [15:0] m_led;
    bit          m_valid = 0;

    function automatic int region_of(input int p);
        if (p > LB) return 1;
        if (p < RB) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_pos = START_POS; m_dir = START_DIR;
            m_since = 0; m_ticks = 0; m_led = '0; m_valid = 1;
        end else begin
            m_region = region_of(m_pos);
            if (m_region == 1)      m_bit = (m_ticks / BL_HALF) % 2;
            else if (m_region == 2) m_bit = (m_ticks / BR_HALF) % 2;
            else                    m_bit = 1;
            m_led = (m_mode != 0 && m_bit == 1) ? (16'h1 << m_pos) : 16'h0;
            if (tick) m_ticks++;
            if (start) begin
                m_mode = 1; m_pos = START_POS; m_dir = START_DIR; m_since = 0;
            end else if (m_mode == 1) begin
                if (pause_tgl) m_mode = 2;
                else if (reverse) begin
                    m_dir = 1 - m_dir; m_since = 0;
                end else if (tick) begin
                    m_since++;
                    m_period = m_dir ? T_UP : T_DOWN;
                    if (m_since == m_period) begin
                        m_since = 0;
                        if (m_dir == 1 && m_pos == N_LED - 1) begin m_pos = N_LED - 2; m_dir = 0; end
                        else if (m_dir == 0 && m_pos == 0)    begin m_pos = 1; m_dir = 1; end
                        else m_pos = m_dir ? m_pos + 1 : m_pos - 1;
                    end
                end
            end else if (m_mode == 2) begin
                if (pause_tgl) m_mode = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_led", int'(led), int'(m_led));
            check("model_pos", int'(pos), m_pos);
            check("model_dir", int'(dir), m_dir);
            check("model_running", int'(running), (m_mode == 1) ? 1 : 0);
            check("model_region", int'(region), region_of(m_pos));
        end
    end

    task automatic drive(input logic t, input logic s, input logic p, input logic r);
        tick = t; start = s; pause_tgl = p; reverse = r;
        @(negedge clk);
        tick = 1'b0; start = 1'b0; pause_tgl = 1'b0; reverse = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        rst = 1'b0;
        check("reset_led", int'(led), 0);
        check("reset_running", int'(running), 0);
        check("reset_pos", int'(pos), 7);
        $display("reset: led=%h pos=%0d dir=%0d running=%0d", led, pos, dir, running);

        drive(0, 0, 1, 1);
        check("idle_ignores_pause", int'(running), 0);

        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        check("start_running", int'(running), 1);
        check("start_led", int'(led), 16'h0080);
        check("start_region", int'(region), 0);
        $display("start: led=%h pos=%0d dir=%0d", led, pos, dir);

        ticks(4);
        check("down_before_step", int'(pos), 7);
        ticks(1);
        check("down_step", int'(pos), 6);
        ticks(30);
        check("reach_zero_pos", int'(pos), 0);
        check("reach_zero_dir", int'(dir), 0);
        ticks(5);
        check("bounce_low_pos", int'(pos), 1);
        check("bounce_low_dir", int'(dir), 1);
        check("right_region", int'(region), 2);
        ticks(3);
        check("up_step_pos", int'(pos), 2);
        $display("low bounce: pos=%0d dir=%0d", pos, dir);

        ticks(1);
        drive(0, 0, 1, 0);
        check("paused_running", int'(running), 0);
        ticks(20);
        check("paused_pos", int'(pos), 2);
        drive(0, 0, 1, 0);
        check("resumed_running", int'(running), 1);
        ticks(1);
        check("resume_hold", int'(pos), 2);
        ticks(1);
        check("resume_step", int'(pos), 3);
        $display("pause/resume: pos=%0d", pos);

        ticks(2);
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 0);
        check("rev_on_step_pos", int'(pos), 3);
        check("rev_on_step_dir", int'(dir), 0);
        ticks(4);
        check("rev_hold", int'(pos), 3);
        ticks(1);
        check("rev_next_step", int'(pos), 2);
        $display("reverse: pos=%0d dir=%0d", pos, dir);

        drive(0, 0, 0, 1);
        ticks(39);
        check("reach_top_pos", int'(pos), 15);
        check("reach_top_dir", int'(dir), 1);
        ticks(3);
        check("bounce_high_pos", int'(pos), 14);
        check("bounce_high_dir", int'(dir), 0);
        check("left_region", int'(region), 1);
        ticks(2);
        check("high_hold", int'(pos), 14);
        $display("high bounce: pos=%0d dir=%0d", pos, dir);

        drive(0, 0, 1, 0);
        drive(0, 1, 1, 0);
        check("start_beats_pause_run", int'(running), 1);
        check("start_beats_pause_pos", int'(pos), 7);
        drive(0, 0, 1, 1);
        check("pause_beats_rev_run", int'(running), 0);
        check("pause_beats_rev_dir", int'(dir), 0);
        drive(0, 0, 1, 0);
        ticks(3);
        $display("priorities: pos=%0d running=%0d", pos, running);

        rst = 1'b1;
        drive(1, 0, 0, 0);
        rst = 1'b0;
        check("midrun_rst_led", int'(led), 0);
        check("midrun_rst_running", int'(running), 0);
        check("midrun_rst_pos", int'(pos), 7);
        check("midrun_rst_dir", int'(dir), 0);
        $display("mid-run reset: led=%h pos=%0d running=%0d", led, pos, running);

        drive(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
